// File: rtl/relu_pkg.sv
// Shared constants, state type and node-selection helper for ReLU stage consumers.
package relu_pkg;

  localparam int RELU_NODES = 4;
  localparam int RELU_VALS  = 4;

  typedef enum logic {IDLE, STREAM} drain_state_t;

  // Returns {found, index} of the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] next_node(input logic [RELU_NODES-1:0] mask,
                                           input logic [2:0]            from);
    logic [2:0] res;
    res = 3'b000;
    for (int i = RELU_NODES - 1; i >= 0; i--) begin
      if (mask[i] && (i >= int'(from))) res = {1'b1, 2'(i)};
    end
    return res;
  endfunction

endpackage

// File: rtl/relu_rise_det.sv
// Registered rising-edge detector; history resets to 1 so a level held through reset is ignored.
module relu_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b1;
    else        level_q <= level;
  end

  assign rise = level & ~level_q;

endmodule

// File: rtl/relu_drain_4n.sv
// Drains a 4-node x 4-value ReLU snapshot one node per valid/ready beat.
// Optional zero-node skipping is enabled with `define RELU_DRAIN_ZERO_SKIP_EN.
module relu_drain_4n
  import relu_pkg::*;
#(
  parameter int DRAIN_SIZE = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         relu_ready,
  input  logic signed [DRAIN_SIZE-1:0] in0_n0,
  input  logic signed [DRAIN_SIZE-1:0] in1_n0,
  input  logic signed [DRAIN_SIZE-1:0] in2_n0,
  input  logic signed [DRAIN_SIZE-1:0] in3_n0,
  input  logic signed [DRAIN_SIZE-1:0] in0_n1,
  input  logic signed [DRAIN_SIZE-1:0] in1_n1,
  input  logic signed [DRAIN_SIZE-1:0] in2_n1,
  input  logic signed [DRAIN_SIZE-1:0] in3_n1,
  input  logic signed [DRAIN_SIZE-1:0] in0_n2,
  input  logic signed [DRAIN_SIZE-1:0] in1_n2,
  input  logic signed [DRAIN_SIZE-1:0] in2_n2,
  input  logic signed [DRAIN_SIZE-1:0] in3_n2,
  input  logic signed [DRAIN_SIZE-1:0] in0_n3,
  input  logic signed [DRAIN_SIZE-1:0] in1_n3,
  input  logic signed [DRAIN_SIZE-1:0] in2_n3,
  input  logic signed [DRAIN_SIZE-1:0] in3_n3,
  output logic signed [DRAIN_SIZE-1:0] out0,
  output logic signed [DRAIN_SIZE-1:0] out1,
  output logic signed [DRAIN_SIZE-1:0] out2,
  output logic signed [DRAIN_SIZE-1:0] out3,
  output logic [1:0]                   out_node,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  typedef logic signed [DRAIN_SIZE-1:0] node_vec_t [RELU_VALS];

  node_vec_t             in_vec [RELU_NODES];
  node_vec_t             buf_q  [RELU_NODES];
  node_vec_t             out_q;
  logic [RELU_NODES-1:0] in_mask;
  logic [RELU_NODES-1:0] mask_q;
  drain_state_t          state;
  logic [1:0]            node_ptr;
  logic                  rise;
  logic                  xfer;
  logic                  last;
  logic                  take;
  logic [2:0]            first_sel;
  logic [2:0]            next_sel;

  relu_rise_det u_rise_det (
    .clk   (clk),
    .rst_n (rst_n),
    .level (relu_ready),
    .rise  (rise)
  );

  assign in_vec[0] = '{in0_n0, in1_n0, in2_n0, in3_n0};
  assign in_vec[1] = '{in0_n1, in1_n1, in2_n1, in3_n1};
  assign in_vec[2] = '{in0_n2, in1_n2, in2_n2, in3_n2};
  assign in_vec[3] = '{in0_n3, in1_n3, in2_n3, in3_n3};

`ifdef RELU_DRAIN_ZERO_SKIP_EN
  always_comb begin
    for (int j = 0; j < RELU_NODES; j++) begin
      in_mask[j] = 1'b0;
      for (int k = 0; k < RELU_VALS; k++) begin
        if (in_vec[j][k] != '0) in_mask[j] = 1'b1;
      end
    end
  end
`else
  // Every node counts as non-zero, so each one produces a beat.
  assign in_mask = '1;
`endif

  assign first_sel = next_node(in_mask, 3'd0);
  assign next_sel  = next_node(mask_q, {1'b0, node_ptr} + 3'd1);
  assign xfer      = out_valid & out_ready;
  assign last      = ~next_sel[2];
  // A new frame is accepted when idle, or back-to-back on the final transfer.
  assign take      = rise & ((state == IDLE) | (xfer & last));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      node_ptr   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      mask_q     <= '0;
      for (int j = 0; j < RELU_NODES; j++) begin
        for (int k = 0; k < RELU_VALS; k++) buf_q[j][k] <= '0;
      end
      for (int k = 0; k < RELU_VALS; k++) out_q[k] <= '0;
    end else begin
      frame_done <= 1'b0;
      if (take) begin
        buf_q  <= in_vec;
        mask_q <= in_mask;
        if (first_sel[2]) begin
          state     <= STREAM;
          out_valid <= 1'b1;
          node_ptr  <= first_sel[1:0];
          out_q     <= in_vec[first_sel[1:0]];
        end else begin
          state      <= IDLE;
          out_valid  <= 1'b0;
          node_ptr   <= '0;
          frame_done <= 1'b1;
        end
      end else if (xfer && last) begin
        state     <= IDLE;
        out_valid <= 1'b0;
        node_ptr  <= '0;
      end else if (xfer) begin
        node_ptr <= next_sel[1:0];
        out_q    <= buf_q[next_sel[1:0]];
      end
      if (xfer && last) frame_done <= 1'b1;
      if (rise && !take) overrun <= 1'b1;
    end
  end

  assign out0     = out_q[0];
  assign out1     = out_q[1];
  assign out2     = out_q[2];
  assign out3     = out_q[3];
  assign out_node = node_ptr;
  assign busy     = (state == STREAM);

endmodule

// File: tb/tb_relu_drain_4n.sv
// Directed self-checking bench for relu_drain_4n; follows RELU_DRAIN_ZERO_SKIP_EN when defined.
module tb_relu_drain_4n;

  localparam int W = 5;

  logic                clk;
  logic                rst_n;
  logic                relu_ready;
  logic                out_ready;
  logic signed [W-1:0] in_v [4][4];
  logic signed [W-1:0] out0, out1, out2, out3;
  logic [1:0]          out_node;
  logic                out_valid;
  logic                busy;
  logic                frame_done;
  logic                overrun;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  relu_drain_4n #(.DRAIN_SIZE(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .relu_ready (relu_ready),
    .in0_n0     (in_v[0][0]),
    .in1_n0     (in_v[0][1]),
    .in2_n0     (in_v[0][2]),
    .in3_n0     (in_v[0][3]),
    .in0_n1     (in_v[1][0]),
    .in1_n1     (in_v[1][1]),
    .in2_n1     (in_v[1][2]),
    .in3_n1     (in_v[1][3]),
    .in0_n2     (in_v[2][0]),
    .in1_n2     (in_v[2][1]),
    .in2_n2     (in_v[2][2]),
    .in3_n2     (in_v[2][3]),
    .in0_n3     (in_v[3][0]),
    .in1_n3     (in_v[3][1]),
    .in2_n3     (in_v[3][2]),
    .in3_n3     (in_v[3][3]),
    .out0       (out0),
    .out1       (out1),
    .out2       (out2),
    .out3       (out3),
    .out_node   (out_node),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame patterns: value k of node j for each stimulus kind.
  function automatic int patVal(input int kind, input int j, input int k);
    case (kind)
      0:       return 4 * j + k;
      1:       return -(4 * j + k + 1);
      2:       return 15 - (4 * j + k);
      3:       return (j == 0) ? k + 1 : (j == 3) ? 4 * j + k : 0;
      4:       return 0;
      default: return ((j * 5 + k * 3) % 11) - 5;
    endcase
  endfunction

  task automatic applyStimulus(input int kind);
    for (int j = 0; j < 4; j++)
      for (int k = 0; k < 4; k++) in_v[j][k] = W'(patVal(kind, j, k));
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    assert_cnt++;
    if (observed !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int kind, input int node);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_node"}, int'(out_node), node);
    checkOutput({tag, "_v0"}, int'(out0), patVal(kind, node, 0));
    checkOutput({tag, "_v1"}, int'(out1), patVal(kind, node, 1));
    checkOutput({tag, "_v2"}, int'(out2), patVal(kind, node, 2));
    checkOutput({tag, "_v3"}, int'(out3), patVal(kind, node, 3));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n      = 1'b0;
    relu_ready = 1'b1;
    out_ready  = 1'b1;
    applyStimulus(0);
    #3;
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(frame_done), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_node", int'(out_node), 0);
    checkOutput("rst_out0", int'(out0), 0);
    tick;
    tick;
    rst_n = 1'b1;

    // relu_ready held high across reset release must not start a frame
    tick;
    tick;
    checkOutput("held_valid", int'(out_valid), 0);
    checkOutput("held_busy", int'(busy), 0);

    // Frame 0..15 with out_ready always high; inputs change after capture
    relu_ready = 1'b0;
    tick;
    relu_ready = 1'b1;
    tick;
    applyStimulus(5);
    for (int n = 0; n < 4; n++) begin
      checkBeat($sformatf("f0_b%0d", n), 0, n);
      checkOutput($sformatf("f0_busy%0d", n), int'(busy), 1);
      checkOutput($sformatf("f0_done%0d", n), int'(frame_done), 0);
      tick;
    end
    checkOutput("f0_end_valid", int'(out_valid), 0);
    checkOutput("f0_end_busy", int'(busy), 0);
    checkOutput("f0_end_done", int'(frame_done), 1);
    checkOutput("f0_end_overrun", int'(overrun), 0);
    tick;
    checkOutput("f0_done_pulse", int'(frame_done), 0);

    // Negative frame with backpressure on node 1
    relu_ready = 1'b0;
    applyStimulus(1);
    tick;
    relu_ready = 1'b1;
    tick;
    checkBeat("f1_b0", 1, 0);
    relu_ready = 1'b0;
    tick;
    checkBeat("f1_b1", 1, 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      checkBeat($sformatf("f1_hold%0d", c), 1, 1);
    end
    out_ready = 1'b1;
    tick;
    checkBeat("f1_b2", 1, 2);
    tick;
    checkBeat("f1_b3", 1, 3);

    // New rise on the final transfer: back-to-back with no bubble
    applyStimulus(2);
    relu_ready = 1'b1;
    tick;
    checkBeat("f2_b0", 2, 0);
    checkOutput("f2_b2b_done", int'(frame_done), 1);
    checkOutput("f2_b2b_overrun", int'(overrun), 0);
    relu_ready = 1'b0;
    applyStimulus(5);
    tick;
    checkBeat("f2_b1", 2, 1);
    checkOutput("f2_done_clear", int'(frame_done), 0);

    // Rise mid-frame is dropped and flagged
    relu_ready = 1'b1;
    tick;
    checkOutput("ovr_set", int'(overrun), 1);
    checkBeat("f2_b2", 2, 2);
    tick;
    checkBeat("f2_b3", 2, 3);
    checkOutput("ovr_sticky", int'(overrun), 1);

    // Asynchronous reset mid-frame
    rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", int'(out_valid), 0);
    checkOutput("arst_node", int'(out_node), 0);
    checkOutput("arst_out0", int'(out0), 0);
    checkOutput("arst_out3", int'(out3), 0);
    checkOutput("arst_overrun", int'(overrun), 0);
    checkOutput("arst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    tick;
    checkOutput("post_rst_valid", int'(out_valid), 0);

    // Frame with zero nodes 1 and 2
    relu_ready = 1'b0;
    applyStimulus(3);
    tick;
    relu_ready = 1'b1;
    tick;
    checkBeat("zf_b0", 3, 0);
    tick;
`ifdef RELU_DRAIN_ZERO_SKIP_EN
    checkBeat("zf_b3", 3, 3);
    tick;
`else
    for (int n = 1; n < 4; n++) begin
      checkBeat($sformatf("zf_b%0d", n), 3, n);
      tick;
    end
`endif
    checkOutput("zf_end_valid", int'(out_valid), 0);
    checkOutput("zf_end_done", int'(frame_done), 1);

    // All-zero frame
    relu_ready = 1'b0;
    applyStimulus(4);
    tick;
    relu_ready = 1'b1;
    tick;
`ifdef RELU_DRAIN_ZERO_SKIP_EN
    checkOutput("az_valid", int'(out_valid), 0);
    checkOutput("az_busy", int'(busy), 0);
    checkOutput("az_done", int'(frame_done), 1);
    tick;
    checkOutput("az_done_clear", int'(frame_done), 0);
`else
    for (int n = 0; n < 4; n++) begin
      checkBeat($sformatf("az_b%0d", n), 4, n);
      tick;
    end
    checkOutput("az_end_valid", int'(out_valid), 0);
    checkOutput("az_done", int'(frame_done), 1);
`endif
    checkOutput("final_overrun", int'(overrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/relu_drain_4n.md
Name: relu_drain_4n

Overview:
Consumer end of the 4-node ReLU stage handshake.
- Snapshots all 16 ReLU outputs (4 nodes x 4 values) on each rising edge of the stage's relu_ready.
- Streams the snapshot to the next layer one node per beat (4 values) over a valid/ready interface.
- Reports busy to the upstream sequencer so it can hold off the next in_ready.

Parameters:
DRAIN_SIZE, 5, signed data width of each value; must equal the ReLU stage width.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
relu_ready  in  1  level "outputs valid" from the ReLU stage; a frame is marked by its rising edge.
in0_n0..in3_n3  in  DRAIN_SIZE each (16 ports, signed)  ReLU outputs; value k of node j is ink_nj.
out0..out3  out  DRAIN_SIZE each (signed)  the 4 values of the current node.
out_node  out  2  index of the node currently presented (0..3).
out_valid  out  1  beat valid.
out_ready  in  1  downstream accept.
busy  out  1  high while a frame is held (state STREAM).
frame_done  out  1  one-cycle pulse after the last beat of a frame transfers.
overrun  out  1  sticky; set when a rising edge is dropped.

Behaviour:
- Reset values: out0..out3=0, out_node=0, out_valid=0, busy=0, frame_done=0, overrun=0, state=IDLE.
- The relu_ready history flop resets to 1, so a relu_ready level held across reset is not captured.
- rise = relu_ready & ~rdy_q, where rdy_q is relu_ready registered every cycle.
- Every arithmetic path is pure capture/mux; values pass through unchanged, with no sign check or clamp.
- FSM states: IDLE, STREAM.
- IDLE:
  - On rise, capture all 16 inputs into the buffer and set node_ptr=0.
  - Go to STREAM; out_valid=1 on the next cycle. Capture-to-valid latency is 1 clock.
- STREAM:
  - out_valid=1; outputs show buffer[node_ptr]. All outputs stay stable while out_valid & ~out_ready.
  - On transfer (out_valid & out_ready) with node_ptr<3: node_ptr++.
- Final transfer (node_ptr==3):
  - If rise occurs in the same cycle, capture the new frame, set node_ptr=0 and stay in STREAM. out_valid stays high with no bubble.
  - Otherwise go to IDLE and deassert out_valid next cycle.
  - In both cases frame_done pulses high on the following cycle.
- rise in STREAM other than on the final-transfer cycle:
  - The frame is dropped, overrun is set, and the buffer is unchanged.
  - overrun clears only on reset.
- busy = (state==STREAM).
- node_ptr is 2 bits and wraps 3->0 only via a new capture or on return to IDLE (where it resets to 0).
- Asynchronous reset mid-frame discards the buffer. The first beat after release requires a new rise.

Optional Feature:
Macro RELU_DRAIN_ZERO_SKIP_EN.
- Defined:
  - A node whose 4 captured values are all zero produces no beat; node_ptr advances past it.
  - Skipping costs 0 cycles: the next non-zero node is selected combinationally from a 4-bit nonzero mask computed at capture.
  - If all 4 nodes are zero, the block stays in IDLE, and frame_done pulses the cycle after capture with no out_valid.
  - The final transfer is the last non-zero node.
- Undefined: every node produces a beat, including all-zero nodes.

Decomposition:
- Shared package relu_pkg:
  - RELU_NODES=4 and RELU_VALS=4 constants.
  - The drain_state_t enum {IDLE, STREAM}.
  - A node_vec_t typedef: array of 4 signed values, parameterised by width via the module.
- One sub-module, relu_rise_det: registered rising-edge detector with reset-to-1 history. It is shared with any future stage consumer.

Test Plan:
1. Reset release with relu_ready held at 1 -> no capture, out_valid=0. Drop relu_ready, raise it at cycle 10 -> out_valid=1 at cycle 11, out_node=0.
2. Frame with inK_nJ = 4*J+K (0..15), out_ready=1 constantly -> 4 beats on consecutive cycles (values 0-3, 4-7, 8-11, 12-15, out_node 0..3). frame_done pulses on the cycle after beat 3. busy=0 afterwards.
3. Backpressure: out_ready=0 for 5 cycles during node 1 -> out1..out3 and out_node=1 stable for all 5 cycles; node 2 follows the first cycle out_ready=1.
4. Second rise in the same cycle as node 3 transfers -> new frame's node 0 on the next cycle with no out_valid gap, frame_done=1 that cycle, overrun stays 0.
5. Rise during node 1 of a frame -> overrun=1 (sticky), remaining beats carry the original frame's values. Assert rst_n=0 mid-frame -> all outputs 0 asynchronously.
6. With RELU_DRAIN_ZERO_SKIP_EN: nodes 1 and 2 all zero -> beats out_node=0, then 3 only. All 16 zero -> no out_valid, frame_done pulses the cycle after capture.
